// File: rtl/calc_rpn_engine_if.sv
// rtl/calc_rpn_engine_if.sv - keypad command strobe and display/status bundle for calc_rpn_engine
interface calc_rpn_engine_if #(
    parameter int NUM_DIGITS = 8,
    parameter int VALUE_W    = 27
);
    logic [3:0]                 cmd;
    logic                       cmd_valid;
    logic [NUM_DIGITS-1:0][6:0] displays;
    logic [1:0]                 status;
    logic [VALUE_W-1:0]         digits;

    modport master (
        output cmd, cmd_valid,
        input  displays, status, digits
    );

    modport slave (
        input  cmd, cmd_valid,
        output displays, status, digits
    );
endinterface

// File: rtl/calc_rpn_engine.sv
// rtl/calc_rpn_engine.sv - two-operand keypad calculator, shift-add multiply, double-dabble display
// Optional negative subtraction results: define CALC_NEG_RESULT_EN.
module calc_rpn_engine #(
    parameter int NUM_DIGITS = 8,
    parameter int VALUE_W    = 27
) (
    input  logic             clock,
    input  logic             reset,
    calc_rpn_engine_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int KW = $clog2(VALUE_W + 1);
    localparam int PW = 2 * VALUE_W;
    localparam int BW = 4 * NUM_DIGITS;

    function automatic logic [PW-1:0] pow10_minus1(input int n);
        logic [PW-1:0] p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam logic [PW-1:0] MAX_VAL = pow10_minus1(NUM_DIGITS);
`ifdef CALC_NEG_RESULT_EN
    localparam logic [PW-1:0] MAX_NEG = pow10_minus1(NUM_DIGITS - 1);
`endif

    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_BKSP = 4'hD;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_CLR  = 4'hF;

    // op holds the low two bits of the operator command
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [NUM_DIGITS-1:0][6:0] DISP_ZERO = {{(NUM_DIGITS-1){SEG_BLANK}}, 7'h40};
    localparam logic [NUM_DIGITS-1:0][6:0] DISP_ERR  = {{(NUM_DIGITS-1){SEG_BLANK}}, 7'h06};

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_CALC,
        ST_RESULT,
        ST_ERROR
    } state_t;

    state_t                     state, state_n;
    logic [VALUE_W-1:0]         a, a_n, b, b_n, cur;
    logic [1:0]                 op, op_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic                       neg, neg_n;

    logic [PW-1:0]              prod, mcand, mul_sum, res;
    logic [VALUE_W-1:0]         mplier;
    logic [KW-1:0]              mcnt;
    logic                       done, res_ok, res_neg;

    logic                       conv_pend, conv_busy, conv_neg;
    logic [KW-1:0]              conv_cnt;
    logic [VALUE_W-1:0]         conv_bin;
    logic [BW-1:0]              conv_bcd, bcd_adj;
    logic [NUM_DIGITS-1:0][6:0] disp, seg_n;
    logic [VALUE_W-1:0]         digits_r, shown_c, shown_n;
    logic                       busy, accept, clr, err_entry, chg, lead;
    logic [3:0]                 dig;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // CALC keeps whatever was on screen so the display does not flicker to an operand
    function automatic logic [VALUE_W-1:0] shown_of(input state_t s, input logic [VALUE_W-1:0] va,
                                                    input logic [VALUE_W-1:0] vb,
                                                    input logic [VALUE_W-1:0] hold);
        case (s)
            ST_ENTRY_B: return vb;
            ST_ERROR:   return '0;
            ST_CALC:    return hold;
            default:    return va;
        endcase
    endfunction

    assign busy   = (state == ST_CALC) || conv_pend || conv_busy;
    assign accept = bus.cmd_valid && !busy;

    always_comb begin
        state_n   = state;
        a_n       = a;
        b_n       = b;
        op_n      = op;
        cnt_n     = cnt;
        neg_n     = neg;
        clr       = 1'b0;
        err_entry = 1'b0;
        cur       = (state == ST_ENTRY_B) ? b : a;
        mul_sum   = prod + (mplier[0] ? mcand : '0);
        res       = '0;
        res_ok    = 1'b0;
        res_neg   = 1'b0;
        done      = 1'b0;

        if (state == ST_CALC) begin
            case (op)
                OP_ADD: begin
                    done   = 1'b1;
                    res    = {{VALUE_W{1'b0}}, a} + {{VALUE_W{1'b0}}, b};
                    res_ok = (res <= MAX_VAL);
                end
                OP_SUB: begin
                    done = 1'b1;
                    if (b <= a) begin
                        res    = {{VALUE_W{1'b0}}, a - b};
                        res_ok = 1'b1;
                    end
`ifdef CALC_NEG_RESULT_EN
                    else begin
                        res     = {{VALUE_W{1'b0}}, b - a};
                        res_neg = 1'b1;
                        res_ok  = (res <= MAX_NEG);
                    end
`endif
                end
                default: begin
                    done   = (mcnt == KW'(VALUE_W - 1));
                    res    = mul_sum;
                    res_ok = (res <= MAX_VAL);
                end
            endcase
            if (neg) res_ok = 1'b0;
        end

        if (accept && bus.cmd == CMD_CLR) begin
            clr     = 1'b1;
            state_n = ST_ENTRY_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            cnt_n   = '0;
            neg_n   = 1'b0;
        end else if (state == ST_CALC) begin
            if (done) begin
                if (res_ok) begin
                    a_n     = res[VALUE_W-1:0];
                    neg_n   = res_neg;
                    state_n = ST_RESULT;
                end else begin
                    state_n   = ST_ERROR;
                    err_entry = 1'b1;
                end
            end
        end else if (accept) begin
            case (state)
                ST_ENTRY_A, ST_ENTRY_B: begin
                    if (bus.cmd <= 4'd9) begin
                        if (cnt != CW'(NUM_DIGITS)) begin
                            if (state == ST_ENTRY_B) b_n = cur * VALUE_W'(10) + VALUE_W'(bus.cmd);
                            else                     a_n = cur * VALUE_W'(10) + VALUE_W'(bus.cmd);
                            if (!(bus.cmd == 4'd0 && cur == '0)) cnt_n = cnt + CW'(1);
                        end
                    end else if (bus.cmd == CMD_BKSP) begin
                        if (state == ST_ENTRY_B) b_n = b / VALUE_W'(10);
                        else                     a_n = a / VALUE_W'(10);
                        if (cnt != '0) cnt_n = cnt - CW'(1);
                    end else if (bus.cmd == CMD_EQ) begin
                        if (state == ST_ENTRY_B) state_n = ST_CALC;
                    end else if (state == ST_ENTRY_A) begin
                        op_n    = bus.cmd[1:0];
                        b_n     = '0;
                        cnt_n   = '0;
                        state_n = ST_ENTRY_B;
                    end else if (cnt == '0) begin
                        op_n = bus.cmd[1:0];
                    end
                end
                ST_RESULT: begin
                    if (bus.cmd <= 4'd9) begin
                        state_n = ST_ENTRY_A;
                        a_n     = VALUE_W'(bus.cmd);
                        cnt_n   = (bus.cmd != 4'd0) ? CW'(1) : CW'(0);
                        neg_n   = 1'b0;
                    end else if (bus.cmd == CMD_EQ) begin
                        state_n = ST_CALC;
                    end else if (bus.cmd >= CMD_ADD && bus.cmd <= CMD_MUL) begin
                        op_n    = bus.cmd[1:0];
                        b_n     = '0;
                        cnt_n   = '0;
                        state_n = ST_ENTRY_B;
                    end
                end
                default: ;
            endcase
        end

        shown_c = shown_of(state, a, b, digits_r);
        shown_n = shown_of(state_n, a_n, b_n, digits_r);
        chg     = !clr && (state_n != ST_ERROR) && (state_n != ST_CALC) &&
                  ((shown_n != shown_c) || (neg_n != neg));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_ENTRY_A;
            a     <= '0;
            b     <= '0;
            op    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            op    <= op_n;
            cnt   <= cnt_n;
            neg   <= neg_n;
        end
    end

    // Multiplier operands track A/B outside CALC so they are ready on the first CALC cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            mcnt   <= '0;
        end else if (state != ST_CALC) begin
            prod   <= '0;
            mcand  <= {{VALUE_W{1'b0}}, a};
            mplier <= b;
            mcnt   <= '0;
        end else begin
            prod   <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mcnt   <= mcnt + KW'(1);
        end
    end

    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (conv_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
        end
        seg_n = {NUM_DIGITS{SEG_BLANK}};
        lead  = 1'b1;
        dig   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig = conv_bcd[4*i +: 4];
            if (lead && dig == 4'd0 && i != 0) begin
                seg_n[i] = SEG_BLANK;
            end else begin
                lead     = 1'b0;
                seg_n[i] = seg_of(dig);
            end
        end
        if (conv_neg) seg_n[NUM_DIGITS-1] = SEG_MINUS;
    end

    // A change is marked pending for one cycle, giving the digit-to-display latency of VALUE_W+2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conv_pend <= 1'b0;
            conv_busy <= 1'b0;
            conv_cnt  <= '0;
            conv_bin  <= '0;
            conv_bcd  <= '0;
            conv_neg  <= 1'b0;
            disp      <= DISP_ZERO;
            digits_r  <= '0;
        end else if (clr) begin
            conv_pend <= 1'b0;
            conv_busy <= 1'b0;
            disp      <= DISP_ZERO;
            digits_r  <= '0;
        end else if (err_entry) begin
            disp      <= DISP_ERR;
            digits_r  <= '0;
        end else begin
            digits_r <= shown_c;
            if (conv_pend) begin
                conv_pend <= 1'b0;
                conv_busy <= 1'b1;
                conv_cnt  <= '0;
                conv_bin  <= shown_c;
                conv_bcd  <= '0;
                conv_neg  <= neg;
            end else if (conv_busy) begin
                if (conv_cnt == KW'(VALUE_W)) begin
                    disp      <= seg_n;
                    conv_busy <= 1'b0;
                end else begin
                    conv_bcd <= {bcd_adj[BW-2:0], conv_bin[VALUE_W-1]};
                    conv_bin <= conv_bin << 1;
                    conv_cnt <= conv_cnt + KW'(1);
                end
            end else if (chg) begin
                conv_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        if (busy) begin
            bus.status = 2'b01;
        end else begin
            case (state)
                ST_RESULT: bus.status = 2'b10;
                ST_ERROR:  bus.status = 2'b11;
                default:   bus.status = 2'b00;
            endcase
        end
    end

    assign bus.displays = disp;
    assign bus.digits   = digits_r;
endmodule

// File: tb/tb_calc_rpn_engine.sv
// tb/tb_calc_rpn_engine.sv - randomized keypad stimulus checked against a decimal calculator model
module tb_calc_rpn_engine;
    localparam int ND = 8;
    localparam int VW = 27;
    localparam int M_EA = 0, M_EB = 1, M_RES = 2, M_ERR = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    calc_rpn_engine_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();
    calc_rpn_engine #(.NUM_DIGITS(ND), .VALUE_W(VW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int              m_state, m_op, m_cnt;
    longint unsigned m_a, m_b;
    bit              m_neg;

    function automatic longint unsigned p10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_reset();
        m_state = M_EA; m_op = 0; m_cnt = 0; m_a = 0; m_b = 0; m_neg = 0;
    endtask

    task automatic model_calc();
        longint unsigned r;
        if (m_neg) begin m_state = M_ERR; return; end
        if (m_op == 11 && m_b > m_a) begin
`ifdef CALC_NEG_RESULT_EN
            r = m_b - m_a;
            if (r > p10(ND - 1) - 1) m_state = M_ERR;
            else begin m_a = r; m_neg = 1; m_state = M_RES; end
`else
            m_state = M_ERR;
`endif
            return;
        end
        if (m_op == 10)      r = m_a + m_b;
        else if (m_op == 11) r = m_a - m_b;
        else                 r = m_a * m_b;
        if (r > p10(ND) - 1) m_state = M_ERR;
        else begin m_a = r; m_neg = 0; m_state = M_RES; end
    endtask

    task automatic model_apply(input int c);
        longint unsigned v;
        if (c == 15) begin model_reset(); return; end
        if (m_state == M_EA || m_state == M_EB) begin
            v = (m_state == M_EB) ? m_b : m_a;
            if (c <= 9 || c == 13) begin
                if (c == 13) begin
                    v = v / 10;
                    if (m_cnt > 0) m_cnt--;
                end else if (m_cnt < ND) begin
                    if (!(c == 0 && v == 0)) m_cnt++;
                    v = v * 10 + longint'(c);
                end
                if (m_state == M_EB) m_b = v; else m_a = v;
            end else if (c == 14) begin
                if (m_state == M_EB) model_calc();
            end else if (m_state == M_EA) begin
                m_op = c; m_b = 0; m_cnt = 0; m_state = M_EB;
            end else if (m_cnt == 0) begin
                m_op = c;
            end
        end else if (m_state == M_RES) begin
            if (c <= 9) begin
                m_state = M_EA; m_a = longint'(c); m_cnt = (c != 0) ? 1 : 0; m_neg = 0;
            end else if (c == 14) begin
                model_calc();
            end else if (c >= 10 && c <= 12) begin
                m_op = c; m_b = 0; m_cnt = 0; m_state = M_EB;
            end
        end
    endtask

    function automatic longint unsigned m_shown();
        if (m_state == M_EB) return m_b;
        if (m_state == M_ERR) return 0;
        return m_a;
    endfunction

    function automatic logic [1:0] m_status();
        if (m_state == M_RES) return 2'b10;
        if (m_state == M_ERR) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [ND-1:0][6:0] m_disp();
        logic [ND-1:0][6:0] d;
        longint unsigned v;
        for (int i = 0; i < ND; i++) d[i] = 7'h7F;
        if (m_state == M_ERR) begin
            d[0] = 7'h06;
        end else begin
            v = m_shown();
            for (int i = 0; i < ND; i++)
                if (i == 0 || v >= p10(i)) d[i] = seg_tab[int'((v / p10(i)) % 10)];
            if (m_neg) d[ND-1] = 7'h3F;
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && !bus.cmd_valid && bus.status != 2'b01) begin
            check("model status", 64'(bus.status), 64'(m_status()));
            check("model digits", 64'(bus.digits), 64'(m_shown()));
            check("model displays", 64'(bus.displays), 64'(m_disp()));
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.status == 2'b01) begin
            @(posedge clock); #1;
            k++;
            if (k > 500) begin
                n_checks++; n_errors++;
                $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
                return;
            end
        end
    endtask

    task automatic send(input int c);
        wait_idle();
        bus.cmd = 4'(c);
        bus.cmd_valid = 1'b1;
        model_apply(c);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_busy(input int c);
        if (bus.status == 2'b01) begin
            bus.cmd = 4'(c);
            bus.cmd_valid = 1'b1;
            @(posedge clock); #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic count_busy(output int k);
        k = 0;
        while (bus.status == 2'b01 && k < 500) begin
            k++;
            @(posedge clock); #1;
        end
    endtask

    logic [ND-1:0][6:0] disp_rst, disp_err;
    int nb;

    initial begin
        for (int i = 0; i < ND; i++) begin disp_rst[i] = 7'h7F; disp_err[i] = 7'h7F; end
        disp_rst[0] = 7'h40;
        disp_err[0] = 7'h06;
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset status", 64'(bus.status), 64'd0);
        check("reset digits", 64'(bus.digits), 64'd0);
        check("reset displays", 64'(bus.displays), 64'(disp_rst));
        reset = 1'b0;
        @(posedge clock); #1;

        send(1); send(10); send(2); send(14); wait_idle();
        check("1+2 digits", 64'(bus.digits), 64'd3);
        check("1+2 status", 64'(bus.status), 64'd2);
        check("1+2 disp0", 64'(bus.displays[0]), 64'h30);
        check("1+2 disp7..1", 64'(bus.displays[ND-1:1]), 64'(disp_rst[ND-1:1]));

        send(15); send(1); send(2); send(12); send(3); send(4); send(14);
        count_busy(nb);
        check("mul busy cycles", 64'(nb), 64'(2 * VW + 2));
        check("12*34 digits", 64'(bus.digits), 64'd408);
        check("12*34 disp2", 64'(bus.displays[2]), 64'h19);
        check("12*34 disp1", 64'(bus.displays[1]), 64'h40);
        check("12*34 disp0", 64'(bus.displays[0]), 64'h00);

        send(15); send(5);
        count_busy(nb);
        check("digit latency", 64'(nb), 64'(VW + 2));

        send(15);
        for (int i = 0; i < 9; i++) send(9);
        wait_idle();
        check("nine 9s digits", 64'(bus.digits), 64'd99999999);
        send(10); send(1); send(14); wait_idle();
        check("overflow status", 64'(bus.status), 64'd3);
        check("overflow disp", 64'(bus.displays), 64'(disp_err));
        send(5); send(10); send(14); send(13); wait_idle();
        check("error sticky", 64'(bus.status), 64'd3);
        send(15);
        check("clear status", 64'(bus.status), 64'd0);
        check("clear digits", 64'(bus.digits), 64'd0);
        check("clear displays", 64'(bus.displays), 64'(disp_rst));

        send(5); send(11); send(7); send(14); wait_idle();
`ifdef CALC_NEG_RESULT_EN
        check("5-7 status", 64'(bus.status), 64'd2);
        check("5-7 digits", 64'(bus.digits), 64'd2);
        check("5-7 disp0", 64'(bus.displays[0]), 64'h24);
        check("5-7 minus", 64'(bus.displays[ND-1]), 64'h3F);
`else
        check("5-7 status", 64'(bus.status), 64'd3);
`endif

        send(15); send(1); send(2); send(3); send(13); wait_idle();
        check("backspace digits", 64'(bus.digits), 64'd12);
        send(4);
        pulse_busy(9);
        wait_idle();
        check("busy drop digits", 64'(bus.digits), 64'd124);

        send(15); send(3); send(12); send(4); send(14);
        repeat (5) @(posedge clock);
        #1;
        check("busy before reset", 64'(bus.status), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid-mul reset status", 64'(bus.status), 64'd0);
        check("mid-mul reset digits", 64'(bus.digits), 64'd0);
        check("mid-mul reset displays", 64'(bus.displays), 64'(disp_rst));
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;

        for (int it = 0; it < 300; it++) begin
            int r, c;
            r = $urandom_range(0, 99);
            if (m_state == M_ERR && r < 40) c = 15;
            else if (r < 50) c = $urandom_range(0, 9);
            else if (r < 62) c = $urandom_range(10, 12);
            else if (r < 70) c = 13;
            else if (r < 88) c = 14;
            else if (r < 93) c = 15;
            else c = $urandom_range(0, 15);
            send(c);
            if ($urandom_range(0, 5) == 0) pulse_busy($urandom_range(0, 15));
        end
        wait_idle();
        repeat (2) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
